alarm_set_controller: RTL and testbench

Sequences the user-facing set buttons of the alarm clock onto the four settable counters (clock, alarm 1, alarm 2, alarm 3). It converts debounced button levels into a registered 2-bit target select `S` and single-cycle `RESET`/`INCREMENT` pulses, which feed the reset/increment steering logic. It also auto-repeats a held increment button and returns the select to the clock counter after a period of inactivity.

---
 rtl/alarm_set_controller.sv | 144 ++++++++++++++
 tb/tb_alarm_set_controller.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_set_controller.sv
// Alarm-clock set-button sequencer: steps the target select, emits single-cycle
// reset/increment pulses with auto-repeat, and falls back to the clock after inactivity.
module alarm_set_controller #(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int TIMEOUT       = 10000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       MODE_BTN,
    input  logic       RESET_BTN,
    input  logic       INC_BTN,
    output logic [1:0] S,
    output logic       RESET,
    output logic       INCREMENT,
    output logic       TIMEOUT_P
);
    // A period of 1 gives $clog2 = 0, so every counter keeps at least one bit.
    localparam int DLY_W = ($clog2(REPEAT_DELAY) < 1) ? 1 : $clog2(REPEAT_DELAY);
    localparam int PER_W = ($clog2(REPEAT_PERIOD) < 1) ? 1 : $clog2(REPEAT_PERIOD);
    localparam int RPT_W = (DLY_W > PER_W) ? DLY_W : PER_W;
    localparam int IDL_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

    localparam logic [RPT_W-1:0] DLY_TC = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_TC = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [IDL_W-1:0] IDL_TC = IDL_W'(TIMEOUT - 1);

    // state     | meaning
    // ST_IDLE   | no increment in progress; waits for an INC rising edge
    // ST_DELAY  | INC held after first pulse; counting to the first auto-repeat
    // ST_REPEAT | INC still held; pulsing every REPEAT_PERIOD cycles
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;

    rpt_state_t       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [IDL_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             mode_prev, reset_prev, inc_prev;
    logic [1:0]       s_d;
    logic             reset_d, inc_d, tp_d;
    logic             mode_edge, reset_edge, inc_edge, any_btn, rpt_pulse;

    // Lower-priority edges are masked by any higher-priority edge in the same cycle.
    assign mode_edge  = MODE_BTN & ~mode_prev;
    assign reset_edge = RESET_BTN & ~reset_prev & ~mode_edge;
    assign inc_edge   = INC_BTN & ~inc_prev & ~mode_edge & ~reset_edge;
    assign any_btn    = MODE_BTN | RESET_BTN | INC_BTN;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            rpt_cnt_q  <= '0;
            idle_cnt_q <= '0;
            mode_prev  <= 1'b1;
            reset_prev <= 1'b1;
            inc_prev   <= 1'b1;
            S          <= 2'b00;
            RESET      <= 1'b0;
            INCREMENT  <= 1'b0;
            TIMEOUT_P  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rpt_cnt_q  <= rpt_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            mode_prev  <= MODE_BTN;
            reset_prev <= RESET_BTN;
            inc_prev   <= INC_BTN;
            S          <= s_d;
            RESET      <= reset_d;
            INCREMENT  <= inc_d;
            TIMEOUT_P  <= tp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rpt_cnt_d  = rpt_cnt_q;
        idle_cnt_d = idle_cnt_q;
        s_d        = S;
        reset_d    = 1'b0;
        inc_d      = 1'b0;
        tp_d       = 1'b0;
        rpt_pulse  = 1'b0;

        if (mode_edge) begin
            s_d        = S + 2'd1;
            state_d    = ST_IDLE;
            rpt_cnt_d  = '0;
            idle_cnt_d = '0;
        end else begin
            reset_d = reset_edge;

            unique case (state_q)
                ST_IDLE: begin
                    if (inc_edge) begin
                        rpt_pulse = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!INC_BTN) begin
                        rpt_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else if (rpt_cnt_q == DLY_TC) begin
                        rpt_pulse = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = ST_REPEAT;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!INC_BTN) begin
                        rpt_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else if (rpt_cnt_q == PER_TC) begin
                        rpt_pulse = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                default: begin
                    rpt_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            endcase

            // A RESET pulse wins the cycle; the repeat schedule keeps running underneath it.
            inc_d = rpt_pulse & ~reset_edge;

            if (S == 2'b00 || any_btn) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == IDL_TC) begin
                idle_cnt_d = '0;
                s_d        = 2'b00;
                tp_d       = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + IDL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alarm_set_controller.sv
// Bench for alarm_set_controller: directed scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the button rules.
module tb_alarm_set_controller;
    localparam int RD = 4;
    localparam int RP = 2;
    localparam int TO = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       MODE_BTN = 1'b0;
    logic       RESET_BTN = 1'b0;
    logic       INC_BTN = 1'b0;
    logic [1:0] S;
    logic       RESET, INCREMENT, TIMEOUT_P;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state: button history, expected outputs, cycles since an
    // accepted INC press (-1 when none), and length of the current idle run.
    logic       m_prev = 1'b1, r_prev = 1'b1, i_prev = 1'b1;
    logic [1:0] exp_s = 2'b00;
    logic       exp_reset = 1'b0, exp_inc = 1'b0, exp_tp = 1'b0;
    int         held_k = -1;
    int         idle_run = 0;

    always #5 CLK = ~CLK;

    alarm_set_controller #(
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .TIMEOUT      (TO)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .MODE_BTN (MODE_BTN),
        .RESET_BTN(RESET_BTN),
        .INC_BTN  (INC_BTN),
        .S        (S),
        .RESET    (RESET),
        .INCREMENT(INCREMENT),
        .TIMEOUT_P(TIMEOUT_P)
    );

    task automatic model_step(input logic m, input logic r, input logic i, input logic rn);
        logic me, re, ie, pulse;
        if (!rn) begin
            m_prev = 1'b1; r_prev = 1'b1; i_prev = 1'b1;
            exp_s = 2'b00; exp_reset = 1'b0; exp_inc = 1'b0; exp_tp = 1'b0;
            held_k = -1; idle_run = 0;
            return;
        end
        me = m & ~m_prev;
        re = r & ~r_prev & ~me;
        ie = i & ~i_prev & ~me & ~re;
        exp_reset = 1'b0; exp_inc = 1'b0; exp_tp = 1'b0;
        if (me) begin
            exp_s = 2'((int'(exp_s) + 1) % 4);
            held_k = -1;
            idle_run = 0;
        end else begin
            exp_reset = re;
            pulse = 1'b0;
            if (held_k < 0) begin
                if (ie) begin
                    pulse = 1'b1;
                    held_k = 0;
                end
            end else if (!i) begin
                held_k = -1;
            end else begin
                held_k++;
                if (held_k == RD || (held_k > RD && (held_k - RD) % RP == 0)) pulse = 1'b1;
            end
            exp_inc = pulse & ~re;
            if (exp_s == 2'b00 || m || r || i) begin
                idle_run = 0;
            end else begin
                idle_run++;
                if (idle_run == TO) begin
                    exp_s = 2'b00;
                    exp_tp = 1'b1;
                    idle_run = 0;
                end
            end
        end
        m_prev = m; r_prev = r; i_prev = i;
    endtask

    task automatic drive(input logic m, input logic r, input logic i, input logic rn);
        MODE_BTN = m; RESET_BTN = r; INC_BTN = i; RST_N = rn;
        @(posedge CLK);
        model_step(m, r, i, rn);
        cyc++;
        #1;
    endtask

    task automatic to_sel(input logic [1:0] target);
        for (int n = 0; n < 4 && exp_s != target; n++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({S, RESET, INCREMENT, TIMEOUT_P} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_state: got S=%b R=%b I=%b T=%b, want all 0", S, RESET, INCREMENT, TIMEOUT_P);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1);
            vectors++;
            if ({S, RESET, INCREMENT, TIMEOUT_P} !== 5'b0) begin
                miscompares++;
                $display("FAIL held_through_reset k=%0d: got S=%b R=%b I=%b T=%b, want all 0", k, S, RESET, INCREMENT, TIMEOUT_P);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (INCREMENT !== 1'b1 || RESET !== 1'b0) begin
            miscompares++;
            $display("FAIL repress_after_reset: got I=%b R=%b, want I=1 R=0", INCREMENT, RESET);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_mode_stepping();
        logic [1:0] want [4];
        want = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (S !== want[n] || S !== exp_s) begin
                miscompares++;
                $display("FAIL mode_step %0d: got S=%b, want %b", n, S, want[n]);
            end
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (S !== 2'b01 || RESET !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_with_reset: got S=%b R=%b, want S=01 R=0", S, RESET);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (RESET !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_with_reset_after: got R=%b, want 0", RESET);
        end
        to_sel(2'b00);
    endtask

    task automatic test_auto_repeat();
        logic want;
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            want = (k == 0 || k == 4 || k == 6 || k == 8);
            vectors++;
            if (INCREMENT !== want || RESET !== 1'b0 || INCREMENT !== exp_inc) begin
                miscompares++;
                $display("FAIL auto_repeat cycle t+%0d: got I=%b R=%b, want I=%b R=0", k + 1, INCREMENT, RESET, want);
            end
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (INCREMENT !== 1'b0) begin
                miscompares++;
                $display("FAIL repeat_after_release k=%0d: got I=%b, want 0", k, INCREMENT);
            end
        end
    endtask

    task automatic test_simul_reset_inc();
        int rst_cnt = 0, inc_cnt = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        rst_cnt += int'(RESET); inc_cnt += int'(INCREMENT);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            rst_cnt += int'(RESET); inc_cnt += int'(INCREMENT);
        end
        vectors++;
        if (rst_cnt != 1 || inc_cnt != 0) begin
            miscompares++;
            $display("FAIL simul_reset_inc: got %0d RESET and %0d INCREMENT pulses, want 1 and 0", rst_cnt, inc_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (INCREMENT !== 1'b1 || RESET !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_repress: got I=%b R=%b, want I=1 R=0", INCREMENT, RESET);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        logic [1:0] want_s;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k <= TO + 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            want_s = (k < TO - 1) ? 2'b10 : 2'b00;
            vectors++;
            if (TIMEOUT_P !== (k == TO - 1) || S !== want_s) begin
                miscompares++;
                $display("FAIL timeout u+%0d: got S=%b T=%b, want S=%b T=%b", k + 1, S, TIMEOUT_P, want_s, (k == TO - 1));
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k <= 16; k++) begin
            drive(1'b0, (k == 5), 1'b0, 1'b1);
            want_s = (k < 13) ? 2'b10 : 2'b00;
            vectors++;
            if (TIMEOUT_P !== (k == 13) || S !== want_s) begin
                miscompares++;
                $display("FAIL timeout_restart u+%0d: got S=%b T=%b, want S=%b T=%b", k + 1, S, TIMEOUT_P, want_s, (k == 13));
            end
        end
        for (int k = 0; k < 3 * TO; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (TIMEOUT_P !== 1'b0 || S !== 2'b00) begin
                miscompares++;
                $display("FAIL no_timeout_at_00 k=%0d: got S=%b T=%b, want S=00 T=0", k, S, TIMEOUT_P);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        to_sel(2'b01);
        for (int k = 0; k < 7; k++) drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (S !== 2'b00 || INCREMENT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_repeat: got S=%b I=%b, want S=00 I=0", S, INCREMENT);
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            vectors++;
            if (S !== 2'b00 || INCREMENT !== 1'b0) begin
                miscompares++;
                $display("FAIL repeat_stopped k=%0d: got S=%b I=%b, want S=00 I=0", k, S, INCREMENT);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic m = 1'b0, r = 1'b0, i = 1'b0, rn;
        int burst = 0;
        for (int n = 0; n < 3000; n++) begin
            if (burst > 0) begin
                m = 1'b0; r = 1'b0; i = 1'b0;
                burst--;
            end else begin
                if ($urandom_range(0, 19) == 0) m = ~m;
                if ($urandom_range(0, 14) == 0) r = ~r;
                if ($urandom_range(0, 9) == 0) i = ~i;
                if ($urandom_range(0, 39) == 0) burst = int'($urandom_range(6, 12));
            end
            rn = ($urandom_range(0, 299) != 0);
            drive(m, r, i, rn);
            vectors++;
            if ({S, RESET, INCREMENT, TIMEOUT_P} !== {exp_s, exp_reset, exp_inc, exp_tp}) begin
                miscompares++;
                $display("FAIL random cyc %0d: got S=%b R=%b I=%b T=%b, want S=%b R=%b I=%b T=%b",
                         cyc, S, RESET, INCREMENT, TIMEOUT_P, exp_s, exp_reset, exp_inc, exp_tp);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mode_stepping();
        test_auto_repeat();
        test_simul_reset_inc();
        test_timeout();
        test_reset_mid_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
